// File: rtl/mem_port.sv
// rtl/mem_port.sv - byte-serial load/store initiator for the single-port data memory
// Optional feature: MEMPORT_BOUNDS_CHECK_EN rejects bursts that would run past the top address.
module mem_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;
    logic              accept;
    logic              cmd_oob;
    logic              last_beat;
    logic              wr_beat;
    logic              rd_advance;

    assign accept    = cmd_valid && cmd_ready;
    assign last_beat = (beats_left == '0);
    assign mem_addr  = cur_addr;
    assign mem_wdata = wr_data;

`ifdef MEMPORT_BOUNDS_CHECK_EN
    // The carry out of start+len means the last beat would land past the top address.
    logic [ADDR_W:0] end_addr;
    assign end_addr = {1'b0, cmd_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, cmd_len};
    assign cmd_oob  = end_addr[ADDR_W];
`else
    assign cmd_oob  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        wr_beat    = 1'b0;
        rd_advance = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid && !cmd_oob) begin
                    state_nxt = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                mem_we   = wr_valid;
                wr_beat  = wr_valid;
                if (wr_valid && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                // A beat may only be fetched once the output register is free or being drained.
                rd_advance = !rd_valid || rd_ready;
                if (rd_advance && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr   <= '0;
            beats_left <= '0;
            err        <= 1'b0;
        end else begin
            err <= accept && cmd_oob;
            if (accept && !cmd_oob) begin
                cur_addr   <= cmd_addr;
                beats_left <= cmd_len;
            end else if (wr_beat || rd_advance) begin
                cur_addr   <= cur_addr + ADDR_ONE;
                beats_left <= beats_left - LEN_ONE;
            end
        end
    end

    // Read output register; a held byte survives into IDLE until the consumer takes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else if (rd_advance) begin
            rd_valid <= 1'b1;
            rd_data  <= mem_rdata;
            rd_last  <= last_beat;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - scoreboard bench for mem_port with a behavioural 256-byte memory
// Build with MEMPORT_BOUNDS_CHECK_EN to exercise the rejected-command path of the wrap test.
module tb_mem_port;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [2:0] cmd_len = 3'd0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       err;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    logic err_exp = 1'b0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    mem_port dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .err       (err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clock) begin : monitor
        wr_exp_t we;
        rd_exp_t re;
        if (mem_we) begin
            we_cnt++;
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: mem_we with addr=%h data=%h, none expected", mem_addr, mem_wdata);
            end else begin
                we = wr_q.pop_front();
                if (mem_addr !== we.addr || mem_wdata !== we.data) begin
                    failures++;
                    $display("FAIL wr_beat: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, we.addr, we.data);
                end
            end
        end
        if (rd_valid && rd_ready) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: byte %h last=%b, none expected", rd_data, rd_last);
            end else begin
                re = rd_q.pop_front();
                if (rd_data !== re.data || rd_last !== re.last) begin
                    failures++;
                    $display("FAIL rd_beat: got data=%h last=%b, expected data=%h last=%b",
                             rd_data, rd_last, re.data, re.last);
                end
            end
        end
        if (err || err_exp) begin
            checks++;
            if (err !== err_exp) begin
                failures++;
                $display("FAIL err_pulse: got %b, expected %b", err, err_exp);
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [2:0] len);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clock);
        while (!cmd_ready && t < 50) begin
            t++;
            @(negedge clock);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, t);
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] d, input bit push);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        if (push) begin
            wr_q.push_back(wr_exp_t'{a, d});
            ref_mem[a] = d;
        end
        @(negedge clock);
        while (!wr_ready && t < 50) begin
            t++;
            @(negedge clock);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_ready: got %b, expected 1", wr_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [2:0] len,
                               input logic [7:0] seed, input logic [7:0] step, input bit gaps);
        logic [7:0] a;
        logic [7:0] d;
        send_cmd(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && i > 0) begin
                wr_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            a = addr + 8'(i);
            d = seed + step * 8'(i);
            drive_beat(a, d, 1'b1);
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [2:0] len,
                              input int stall_after, input int stall_cycles, output int cyc);
        int  n = 0;
        int  stall = stall_cycles;
        bit  done = 0;
        logic [7:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 8'(i);
            rd_q.push_back(rd_exp_t'{ref_mem[a], (i == int'(len))});
        end
        cyc = 0;
        rd_ready = 1'b1;
        send_cmd(1'b0, addr, len);
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (!rd_ready) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_q.size() == 0 || rd_data !== rd_q[0].data) begin
                    failures++;
                    $display("FAIL rd_hold: rd_valid=%b rd_data=%h while stalled", rd_valid, rd_data);
                end
            end
            if (rd_valid && rd_ready) begin
                n++;
                if (rd_last) done = 1;
            end
            @(posedge clock);
            #1;
            rd_ready = !(n == stall_after && stall > 0);
            if (!rd_ready) stall--;
        end
        rd_ready = 1'b1;
        checks++;
        if (!done || n != int'(len) + 1) begin
            failures++;
            $display("FAIL rd_burst_len: consumed %0d bytes (done=%0b), expected %0d", n, done, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        wr_data = 8'h3C;
        repeat (2) @(negedge clock);
        checks += 10;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready); end
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready: got %b, expected 0", wr_ready); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b, expected 0", rd_valid); end
        if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %h, expected 00", rd_data); end
        if (rd_last !== 1'b0) begin failures++; $display("FAIL reset_rd_last: got %b, expected 0", rd_last); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b, expected 0", err); end
        if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b, expected 0", mem_we); end
        if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr: got %h, expected 00", mem_addr); end
        if (mem_wdata !== 8'h3C) begin failures++; $display("FAIL reset_mem_wdata: got %h, expected 3c", mem_wdata); end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single_write();
        int c0 = we_cnt;
        write_burst(8'h10, 3'd0, 8'hA5, 8'h00, 1'b0);
        @(negedge clock);
        checks += 4;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL single_cmd_ready: got %b, expected 1", cmd_ready); end
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b, expected 0", busy); end
        if (we_cnt - c0 != 1) begin failures++; $display("FAIL single_we_count: got %0d, expected 1", we_cnt - c0); end
        if (mem[8'h10] !== 8'hA5) begin failures++; $display("FAIL single_mem: got %h, expected a5", mem[8'h10]); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_read_burst();
        int cyc;
        write_burst(8'h20, 3'd3, 8'h11, 8'h11, 1'b0);
        read_burst(8'h20, 3'd3, 99, 0, cyc);
        checks++;
        if (cyc != 5) begin failures++; $display("FAIL read_latency: got %0d cycles, expected 5", cyc); end
    endtask

    task automatic test_back_pressure();
        int cyc;
        write_burst(8'h60, 3'd7, 8'($urandom_range(255)), 8'h07, 1'b0);
        read_burst(8'h60, 3'd7, 2, 3, cyc);
        checks++;
        if (cyc != 12) begin failures++; $display("FAIL bp_cycles: got %0d cycles, expected 12", cyc); end
    endtask

    task automatic test_wrap();
        int c0 = we_cnt;
`ifdef MEMPORT_BOUNDS_CHECK_EN
        send_cmd(1'b1, 8'hFE, 3'd3);
        err_exp = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        @(negedge clock);
        checks += 2;
        if (err !== 1'b1) begin failures++; $display("FAIL wrap_err: got %b, expected 1", err); end
        if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy: got %b, expected 0", busy); end
        @(posedge clock);
        #1;
        err_exp = 1'b0;
        repeat (4) begin
            @(negedge clock);
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_hold: got %b, expected 0", busy); end
        end
        wr_valid = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (we_cnt != c0) begin failures++; $display("FAIL wrap_we_count: got %0d, expected 0", we_cnt - c0); end
`else
        int cyc;
        write_burst(8'hFE, 3'd3, 8'hD0, 8'h01, 1'b0);
        checks++;
        if (we_cnt - c0 != 4) begin failures++; $display("FAIL wrap_we_count: got %0d, expected 4", we_cnt - c0); end
        read_burst(8'hFE, 3'd3, 99, 0, cyc);
`endif
    endtask

    task automatic test_write_gaps();
        int c0 = we_cnt;
        write_burst(8'h80, 3'd3, 8'($urandom_range(255)), 8'h03, 1'b1);
        checks++;
        if (we_cnt - c0 != 4) begin failures++; $display("FAIL gaps_we_count: got %0d, expected 4", we_cnt - c0); end
    endtask

    task automatic test_reset_mid_burst();
        write_burst(8'h40, 3'd7, 8'hC0, 8'h01, 1'b0);
        send_cmd(1'b1, 8'h40, 3'd7);
        drive_beat(8'h40, 8'h5A, 1'b1);
        drive_beat(8'h41, 8'h5B, 1'b1);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        reset_n  = 1'b0;
        #1;
        checks += 5;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b, expected 0", mem_we); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready: got %b, expected 0", wr_ready); end
        if (mem_addr !== 8'h00) begin failures++; $display("FAIL rst_mem_addr: got %h, expected 00", mem_addr); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid: got %b, expected 0", rd_valid); end
        @(negedge clock);
        @(negedge clock);
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 2; i < 8; i++) begin
            checks++;
            if (mem[8'h40 + 8'(i)] !== ref_mem[8'h40 + 8'(i)]) begin
                failures++;
                $display("FAIL rst_mem_kept[%0d]: got %h, expected %h", i, mem[8'h40 + 8'(i)], ref_mem[8'h40 + 8'(i)]);
            end
        end
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready: got %b, expected 1", cmd_ready); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        write_burst(8'h90, 3'd1, 8'($urandom_range(255)), 8'h21, 1'b0);
        read_burst(8'h90, 3'd1, 99, 0, cyc);
        read_burst(8'h10, 3'd0, 99, 0, cyc);
        checks++;
        if (cyc != 2) begin failures++; $display("FAIL b2b_latency: got %0d cycles, expected 2", cyc); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_back_pressure();
        test_wrap();
        test_write_gaps();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (3) @(negedge clock);
        checks += 2;
        if (wr_q.size() != 0) begin failures++; $display("FAIL wr_q_drained: %0d beats left, expected 0", wr_q.size()); end
        if (rd_q.size() != 0) begin failures++; $display("FAIL rd_q_drained: %0d bytes left, expected 0", rd_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
